seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised, time-multiplexed driver for a bank of common-anode 7-segment digits with active-low segments and anodes. It takes packed BCD digits plus decimal points, holds them in a tear-free display register, and scans one digit at a time at a programmable refresh rate. It sits between the BCD converter datapath and the board's display pins, and replaces per-digit combinational decoders.

## Interface
- DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000, clk cycles each digit is held; legal minimum 2.
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  synchronous, active-high reset.
- bcd_in  in  4*DIGITS  packed digits; bcd_in[3:0] is digit 0, the least significant and rightmost digit.
- dp_in  in  DIGITS  decimal point request per digit, active-high.
- load  in  1  single-cycle strobe that captures bcd_in and dp_in.
- blank  in  1  when 1, all anodes are driven off.
- a_to_g  out  7  segments a..g, MSB = a, active-low.
- dp  out  1  decimal point segment, active-low.
- an  out  DIGITS  anode enables, active-low; an[i] selects digit i.
- frame_start  out  1  one-cycle pulse marking the start of each digit-0 slot.

## Operation
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps. tick = (cnt == REFRESH_DIV-1).
- Digit index idx (0..DIGITS-1) advances on tick and wraps from DIGITS-1 to 0.
- Pending register: load=1 copies bcd_in/dp_in into pend and sets pend_v=1.
- Display register disp:
  - On a tick where idx wraps to 0 and pend_v=1, disp takes pend (its value before the edge) and pend_v clears.
  - If load coincides with that tick, the transfer uses the old pend, the new data lands in pend, and pend_v stays 1.
  - The displayed frame therefore never mixes two loads.
- Decode of disp nibble idx (a_to_g, active-low):
  - 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100
  - 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100
  - 10..15 → 1111111 (blank segments; never high-Z).
- dp = ~disp_dp[idx].
- an = all ones except an[idx]=0. blank=1, or a suppressed digit (see Configuration), forces an all ones and dp=1.
- frame_start = 1 for exactly the one cycle in which the registered outputs first show idx 0.

## Timing
- All outputs are registered and show the state of idx/disp with 1 cycle latency.
- Reset (clr=1 at an edge): cnt=0, idx=0, disp=0, pend=0, pend_v=0, an=all ones, a_to_g=1111111, dp=1, frame_start=0.
- On the first edge after clr deasserts, outputs show idx 0 and frame_start=1. Each digit is then held exactly REFRESH_DIV cycles, giving a frame of DIGITS*REFRESH_DIV cycles.
- clr mid-scan takes effect at the next edge and discards pending data.
- load does not affect the prescaler or idx.
- DIGITS=1: idx stays 0, and frame_start pulses every REFRESH_DIV cycles.
- Internal widths: cnt is $clog2(REFRESH_DIV) bits; idx is max(1,$clog2(DIGITS)) bits.

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking. A digit i>0 is suppressed when it and every digit above it are 0 in disp. Suppressed means its anode stays 1 and dp=1, even if its dp_in bit was set. Digit 0 is never suppressed.
- SEG7_LZB_EN undefined: every digit is driven; zeros are shown as 0.

## Test plan
Bench parameters: DIGITS=4, REFRESH_DIV=4.
- Reset: hold clr 3 cycles -> an=1111, a_to_g=1111111, dp=1, frame_start=0; on the first edge after release -> frame_start=1, an=1110.
- load bcd_in=16'h1234, dp_in=4'b0100 -> from the next frame, each slot held 4 cycles:
  - an=1110 with a_to_g=1001100
  - an=1101 with a_to_g=0000110
  - an=1011 with a_to_g=0010010 and dp=0
  - an=0111 with a_to_g=1001111
- Invalid code: load 16'h12B4 -> during the an=1101 slot, a_to_g=1111111 (no X/Z).
- Tear-free: show 16'h1234, then load 16'h5678 during the an=1101 slot -> that frame finishes with 2,1; the next frame shows 8,7,6,5.
- blank=1 for one full frame -> an=1111 and dp=1 throughout; scan timing and frame_start cadence are unchanged.
- LZB: load 16'h0040 -> with SEG7_LZB_EN, the an=1011 and an=0111 slots keep an=1111, while digits 1 (4) and 0 (0) are shown. Without the macro, all four digits are shown as 0,4,0,0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with a tear-free display register.
// Define SEG7_LZB_EN to enable leading-zero blanking of digits above digit 0.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank,
  output logic [6:0]            a_to_g,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   pend;
  logic [4*DIGITS-1:0]   disp;
  logic [DIGITS-1:0]     pend_dp;
  logic [DIGITS-1:0]     disp_dp;
  logic                  pend_v;

  logic                  tick;
  logic                  wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_sup;
  logic [DIGITS-1:0]     sel;
  logic [DIGITS-1:0]     sup;

  assign tick = (cnt == CNT_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

`ifdef SEG7_LZB_EN
  // A digit is suppressed when it and every more significant digit are zero.
  always_comb begin : lzb
    logic zero_above;
    zero_above = 1'b1;
    sup        = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (disp[4*i +: 4] == 4'd0);
      if (i > 0) sup[i] = zero_above;
    end
  end
`else
  assign sup = '0;
`endif

  always_comb begin
    cur_nib = 4'd0;
    cur_dp  = 1'b0;
    cur_sup = 1'b0;
    sel     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = disp[4*i +: 4];
        cur_dp  = disp_dp[i];
        cur_sup = sup[i];
        sel[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt         <= '0;
      idx         <= '0;
      disp        <= '0;
      disp_dp     <= '0;
      pend        <= '0;
      pend_dp     <= '0;
      pend_v      <= 1'b0;
      an          <= '1;
      a_to_g      <= 7'b1111111;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);

      // A load on the wrap tick goes to pend after the old pend has moved to disp.
      if (wrap && pend_v) begin
        disp    <= pend;
        disp_dp <= pend_dp;
        pend_v  <= 1'b0;
      end
      if (load) begin
        pend    <= bcd_in;
        pend_dp <= dp_in;
        pend_v  <= 1'b1;
      end

      a_to_g      <= seg_decode(cur_nib);
      frame_start <= (cnt == '0) && (idx == '0);
      if (blank || cur_sup) begin
        an <= '1;
        dp <= 1'b1;
      end else begin
        an <= ~sel;
        dp <= ~cur_dp;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4); every output cycle is checked.
module tb_seg7_scan_driver;

  logic        clk;
  logic        clr;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank;
  logic [6:0]  a_to_g;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  // Entry layout: {an[3:0], a_to_g[6:0], dp, frame_start}
  logic [12:0] exp_q[$];
  int          tag_q[$];
  int          errors = 0;
  int          checks = 0;

  seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .clr(clr), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .blank(blank), .a_to_g(a_to_g), .dp(dp), .an(an), .frame_start(frame_start)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference tables ----------------
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: seg_of = 7'b0000001;
      4'd1: seg_of = 7'b1001111;
      4'd2: seg_of = 7'b0010010;
      4'd3: seg_of = 7'b0000110;
      4'd4: seg_of = 7'b1001100;
      4'd5: seg_of = 7'b0100100;
      4'd6: seg_of = 7'b0100000;
      4'd7: seg_of = 7'b0001111;
      4'd8: seg_of = 7'b0000000;
      4'd9: seg_of = 7'b0000100;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] show_mask(input logic [15:0] d);
    logic z;
    show_mask = 4'hF;
    z = 1'b1;
`ifdef SEG7_LZB_EN
    for (int i = 3; i >= 1; i--) begin
      z = z & (d[i*4 +: 4] == 4'd0);
      if (z) show_mask[i] = 1'b0;
    end
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_reset(input int tag);
    exp_q.push_back({4'hF, 7'b1111111, 1'b1, 1'b0});
    tag_q.push_back(tag);
  endtask

  // One frame (or its first len cycles) of expected outputs for display value d.
  task automatic do_frame(input int fno, input logic [15:0] d, input logic [3:0] dpo,
                          input logic blk, input int len,
                          input int la, input logic [15:0] lda, input logic [3:0] ldpa,
                          input int lb, input logic [15:0] ldb, input logic [3:0] ldpb,
                          input logic blank_next);
    logic [3:0] show;
    logic [3:0] e_an;
    logic       e_dp;
    show = blk ? 4'h0 : show_mask(d);
    for (int c = 0; c < len; c++) begin
      int s;
      s = c / 4;
      @(posedge clk);
      #1;
      load = 1'b0;
      e_an = show[s] ? ~(4'b0001 << s) : 4'hF;
      e_dp = ~(show[s] & dpo[s]);
      exp_q.push_back({e_an, seg_of(d[s*4 +: 4]), e_dp, (c == 0)});
      tag_q.push_back(fno);
      if (c == la) begin bcd_in = lda; dp_in = ldpa; load = 1'b1; end
      if (c == lb) begin bcd_in = ldb; dp_in = ldpb; load = 1'b1; end
      if (c == 15) blank = blank_next;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [12:0] exp_v;
  logic [12:0] got_v;
  int          tag_v;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tag_v = tag_q.pop_front();
      got_v = {an, a_to_g, dp, frame_start};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL frame%0d outputs: got an=%b seg=%b dp=%b fs=%b expected an=%b seg=%b dp=%b fs=%b",
                 tag_v, got_v[12:9], got_v[8:2], got_v[1], got_v[0],
                 exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clr = 1'b1; load = 1'b0; blank = 1'b0; bcd_in = '0; dp_in = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
      push_reset(-1);
    end
    clr = 1'b0;

    // Empty display, then 1234 with dp on digit 2
    do_frame(0,  16'h0000, 4'b0000, 1'b0, 16, 2,  16'h1234, 4'b0100, -1, 16'h0, 4'b0, 1'b0);
    do_frame(1,  16'h1234, 4'b0100, 1'b0, 16, 3,  16'h12B4, 4'b0000, -1, 16'h0, 4'b0, 1'b0);
    // Non-BCD nibble in digit 1
    do_frame(2,  16'h12B4, 4'b0000, 1'b0, 16, 3,  16'h1234, 4'b0000, -1, 16'h0, 4'b0, 1'b0);
    // Load mid-frame during digit-1 slot must not tear the current frame
    do_frame(3,  16'h1234, 4'b0000, 1'b0, 16, 5,  16'h5678, 4'b0000, -1, 16'h0, 4'b0, 1'b0);
    do_frame(4,  16'h5678, 4'b0000, 1'b0, 16, -1, 16'h0,    4'b0000, -1, 16'h0, 4'b0, 1'b1);
    // Blanked frame keeps scan timing and frame_start
    do_frame(5,  16'h5678, 4'b0000, 1'b1, 16, -1, 16'h0,    4'b0000, -1, 16'h0, 4'b0, 1'b0);
    do_frame(6,  16'h5678, 4'b0000, 1'b0, 16, 3,  16'h0040, 4'b0010, -1, 16'h0, 4'b0, 1'b0);
    // Leading zeros; second load coincides with the wrap tick
    do_frame(7,  16'h0040, 4'b0010, 1'b0, 16, 3,  16'h9090, 4'b1000, 14, 16'h0007, 4'b0001, 1'b0);
    do_frame(8,  16'h9090, 4'b1000, 1'b0, 16, -1, 16'h0,    4'b0000, -1, 16'h0, 4'b0, 1'b0);
    do_frame(9,  16'h0007, 4'b0001, 1'b0, 16, -1, 16'h0,    4'b0000, -1, 16'h0, 4'b0, 1'b0);
    // Reset mid-scan discards the pending 8888
    do_frame(10, 16'h0007, 4'b0001, 1'b0, 9,  5,  16'h8888, 4'b1111, -1, 16'h0, 4'b0, 1'b0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    push_reset(-2);
    do_frame(11, 16'h0000, 4'b0000, 1'b0, 16, -1, 16'h0,    4'b0000, -1, 16'h0, 4'b0, 1'b0);
    do_frame(12, 16'h0000, 4'b0000, 1'b0, 16, -1, 16'h0,    4'b0000, -1, 16'h0, 4'b0, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: run exceeded time limit, got no end, required end of stimulus");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
